// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, instruction size, fetch FSM encodings.
// Latency: none (declarations only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // Canonical ADDI x0,x0,0; decode substitutes it for a flushed slot.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_TRAP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ready/rvalid channel plus the decode valid/ready channel.
// Latency: none (wires only).
// Backpressure: imem_ready stalls requests, if_ready stalls the decode hand-off.
interface pc_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_ready;

    // Fetch unit side.
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher feeding a one-entry decode buffer.
// Latency: REQ->WAIT->HOLD, one instruction per 3 cycles with zero-wait memory; redirect from HOLD requests the target next cycle.
// Backpressure: imem_ready holds the request (address stable); if_ready=0 holds the buffer and blocks the next fetch.
module pc_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   br_target,
    output logic              misalign_exc,
    pc_fetch_unit_if.master   bus
);
    import riscv_pkg::*;

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] if_pc_q;
    logic [31:0]     if_instr_q;
    logic            valid_q;
    logic            kill, kill_n;
    logic            redir_pend, pend_n;
    logic            mis_q;

    logic            redir;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic            load_buf;
    logic            drop_buf;
    logic            to_trap;

    // Only a taken branch redirects; bit0 of the target is always cleared.
    assign redir   = br_valid & branch_taken;
    assign tgt     = br_target & {{(XLEN-1){1'b1}}, 1'b0};
    assign tgt_mis = tgt[1];

    // Next-state, next-PC and buffer-control decode.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        kill_n   = kill;
        pend_n   = redir_pend;
        load_buf = 1'b0;
        drop_buf = 1'b0;
        to_trap  = 1'b0;

        case (state)
            S_IDLE: begin
                if (redir && tgt_mis) begin
                    to_trap = 1'b1;
                end else begin
                    state_n = S_REQ;
                    if (redir) pc_n = tgt;
                end
            end
            S_REQ: begin
                if (redir && tgt_mis) begin
                    to_trap = 1'b1;
                end else begin
                    // The presented address must not move, so a redirect is parked in pc.
                    if (redir) begin
                        pc_n   = tgt;
                        pend_n = 1'b1;
                    end
                    if (bus.imem_ready) begin
                        state_n = S_WAIT;
                        kill_n  = redir | redir_pend;
                        pend_n  = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (redir && tgt_mis) begin
                    to_trap = 1'b1;
                end else if (bus.imem_rvalid) begin
                    if (kill || redir) begin
                        kill_n  = 1'b0;
                        state_n = S_REQ;
                        if (redir) pc_n = tgt;
                    end else begin
                        load_buf = 1'b1;
                        state_n  = S_HOLD;
                    end
                end else if (redir) begin
                    kill_n = 1'b1;
                    pc_n   = tgt;
                end
            end
            S_HOLD: begin
                if (redir && tgt_mis) begin
                    to_trap = 1'b1;
                end else if (redir) begin
                    drop_buf = 1'b1;
                    pc_n     = tgt;
                    state_n  = S_REQ;
                end else if (bus.if_ready) begin
                    drop_buf = 1'b1;
                    pc_n     = if_pc_q + XLEN'(INSTR_BYTES);
                    state_n  = S_REQ;
                end
            end
            S_TRAP: begin
                state_n = S_TRAP;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (to_trap) begin
            state_n  = S_TRAP;
            kill_n   = 1'b0;
            pend_n   = 1'b0;
            drop_buf = 1'b1;
        end
    end

    // FSM, PC and redirect bookkeeping registers; the exception flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            redir_pend <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            kill       <= kill_n;
            redir_pend <= pend_n;
            if (to_trap) mis_q <= 1'b1;
        end
    end

    // Request address is captured only on entry to S_REQ so it stays put while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= RESET_PC;
        end else if ((state != S_REQ) && (state_n == S_REQ)) begin
            addr_q <= pc_n;
        end
    end

    // One-entry output buffer toward decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else if (load_buf) begin
            valid_q    <= 1'b1;
            if_pc_q    <= addr_q;
            if_instr_q <= bus.imem_rdata;
        end else if (drop_buf) begin
            valid_q    <= 1'b0;
        end
    end

    assign bus.imem_req  = (state == S_REQ);
    assign bus.imem_addr = addr_q;
    // A redirect in the same cycle makes the buffered instruction wrong-path, so hide it.
    assign bus.if_valid  = valid_q & ~redir;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;
    assign misalign_exc  = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder, stream-level reference model, directed and random phases.
// Latency: n/a.
// Backpressure: randomised imem_ready, response latency and if_ready.
module tb_pc_fetch_unit;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic        branch_taken;
    logic [31:0] br_target;
    logic        misalign_exc;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.XLEN(W)) bus ();

    pc_fetch_unit #(.XLEN(W), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_valid     (br_valid),
        .branch_taken (branch_taken),
        .br_target    (br_target),
        .misalign_exc (misalign_exc),
        .bus          (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // memory responder state
    bit          outstanding;
    int          lat;
    int          lat_lo, lat_hi;
    logic [31:0] pend_addr;
    bit          stale_rv;

    // reference model state
    logic [31:0] exp_pc;
    bit          trapped;
    bit          prev_stall;
    logic [31:0] prev_addr;
    int          idle_cnt;

    // negedge samples
    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_pc, s_instr;

    // transaction records since last reset release
    logic [31:0] acc_q[$];
    logic [31:0] dlv_pc[$];
    int          dlv_cyc[$];
    int          cyc;
    int          first_req_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream-level rules: delivered pc follows the last redirect target or previous pc+4,
    // instruction matches memory, request address is stable while stalled, trap is terminal.
    task automatic model_check();
        logic        redir;
        logic [31:0] tgt;
        if (!rst_n) begin
            chk("rst_req",   s_req,   1'b0);
            chk("rst_addr",  s_addr,  RPC);
            chk("rst_valid", s_valid, 1'b0);
            chk("rst_if_pc", s_pc,    32'h0);
            chk("rst_instr", s_instr, 32'h0);
            chk("rst_mis",   s_mis,   1'b0);
            exp_pc      = RPC;
            trapped     = 1'b0;
            prev_stall  = 1'b0;
            idle_cnt    = 0;
            outstanding = 1'b0;
            return;
        end
        redir = br_valid & branch_taken;
        tgt   = br_target & ~32'h1;
        if (trapped) begin
            chk("trap_mis",   s_mis,   1'b1);
            chk("trap_req",   s_req,   1'b0);
            chk("trap_valid", s_valid, 1'b0);
        end else begin
            chk("mis_clear", s_mis, 1'b0);
            if (prev_stall) chk("addr_hold", {s_req, s_addr}, {1'b1, prev_addr});
            if (redir) begin
                chk("valid_masked", s_valid, 1'b0);
            end else if (s_valid) begin
                chk("if_pc",    s_pc,    exp_pc);
                chk("if_instr", s_instr, mem_word(exp_pc));
            end
            idle_cnt++;
            if (redir && tgt[1]) begin
                trapped = 1'b1;
            end else if (redir) begin
                exp_pc   = tgt;
                idle_cnt = 0;
            end else if (s_valid && bus.if_ready) begin
                exp_pc   = exp_pc + 32'd4;
                idle_cnt = 0;
            end
            if (idle_cnt > 200) begin
                n_vec++;
                n_fail++;
                $display("FAIL progress: no delivery for %0d cycles, required <= 200", idle_cnt);
                idle_cnt = 0;
            end
        end
        prev_stall = s_req & ~bus.imem_ready;
        prev_addr  = s_addr;
    endtask

    // One clock: drive response, sample at negedge, check, record, return at posedge+1.
    task automatic step();
        if (stale_rv) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            stale_rv        = 1'b0;
        end else if (outstanding && lat == 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr);
            outstanding     = 1'b0;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (outstanding) lat--;
        end
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        s_pc    = bus.if_pc;
        s_instr = bus.if_instr;
        s_mis   = misalign_exc;
        model_check();
        if (rst_n) begin
            if (s_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (s_req && bus.imem_ready) begin
                chk("one_outstanding", outstanding, 1'b0);
                outstanding = 1'b1;
                pend_addr   = s_addr;
                lat         = $urandom_range(lat_hi, lat_lo);
                acc_q.push_back(s_addr);
            end
            if (s_valid && bus.if_ready) begin
                dlv_pc.push_back(s_pc);
                dlv_cyc.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic t, input logic [31:0] a);
        br_valid     = v;
        branch_taken = t;
        br_target    = a;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        acc_q.delete();
        dlv_pc.delete();
        dlv_cyc.delete();
        cyc           = 0;
        first_req_cyc = -1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        set_br(1'b0, 1'b0, 32'h0);
        bus.imem_ready = 1'b0;
        bus.if_ready   = 1'b0;
        repeat (2) step();
        release_rst();
    endtask

    task automatic rand_inputs();
        logic [31:0] a;
        bus.imem_ready = ($urandom_range(99, 0) < 70);
        bus.if_ready   = ($urandom_range(99, 0) < 60);
        a = ($urandom & 32'h0000_03FC) | ($urandom & 32'h1);
        if ($urandom_range(15, 0) == 0)  a = a | 32'hFFFF_F000;
        if ($urandom_range(399, 0) == 0) a = a | 32'h2;
        set_br($urandom_range(99, 0) < 12, $urandom_range(1, 0) == 1, a);
    endtask

    initial begin
        int a0, n0;
        rst_n          = 1'b0;
        set_br(1'b0, 1'b0, 32'h0);
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.if_ready   = 1'b0;
        outstanding    = 1'b0;
        stale_rv       = 1'b0;
        lat            = 0;
        lat_lo         = 1;
        lat_hi         = 1;
        cyc            = 0;
        first_req_cyc  = -1;
        @(posedge clk);
        #1;

        // Sequential stream, clean and with not-taken branches pinned to 0x200.
        for (int ph = 0; ph < 2; ph++) begin
            lat_lo = 1; lat_hi = 1;
            do_reset();
            bus.imem_ready = 1'b1;
            bus.if_ready   = 1'b1;
            set_br(ph == 1, 1'b0, 32'h200);
            repeat (12) step();
            chk("first_req_cyc", first_req_cyc, 1);
            chk("seq_acc0", acc_q[0], 32'h0);
            chk("seq_acc1", acc_q[1], 32'h4);
            chk("seq_acc2", acc_q[2], 32'h8);
            chk("seq_dlv0", dlv_pc[0], 32'h0);
            chk("seq_dlv2", dlv_pc[2], 32'h8);
            chk("seq_gap1", dlv_cyc[1] - dlv_cyc[0], 3);
            chk("seq_gap2", dlv_cyc[2] - dlv_cyc[1], 3);
        end
        set_br(1'b0, 1'b0, 32'h0);

        // Decode stalls 5 cycles with the first instruction buffered.
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (3) step();
        repeat (5) begin
            step();
            chk("hold_valid", s_valid, 1'b1);
            chk("hold_instr", s_instr, 32'h0050_0093);
            chk("hold_noreq", s_req, 1'b0);
        end
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        step();
        chk("hold_next_req", {s_req, s_addr}, {1'b1, 32'h4});

        // Redirect while the fetch of 0x8 is outstanding.
        lat_lo = 2; lat_hi = 2;
        do_reset();
        bus.imem_ready = 1'b1;
        bus.if_ready   = 1'b1;
        for (int i = 0; i < 40 && !(acc_q.size() > 0 && acc_q[$] == 32'h8); i++) step();
        chk("wait_saw_acc8", acc_q[$], 32'h8);
        a0 = acc_q.size();
        n0 = dlv_pc.size();
        set_br(1'b1, 1'b1, 32'h40);
        step();
        set_br(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40 && dlv_pc.size() <= n0; i++) step();
        chk("wait_redir_req", acc_q[a0], 32'h40);
        chk("wait_redir_pc",  dlv_pc[n0], 32'h40);

        // Redirect while the request for 0x8 is stalled by imem_ready=0.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        bus.imem_ready = 1'b1;
        bus.if_ready   = 1'b1;
        for (int i = 0; i < 40 && !(dlv_pc.size() > 0 && dlv_pc[$] == 32'h4); i++) step();
        bus.imem_ready = 1'b0;
        set_br(1'b1, 1'b1, 32'h100);
        step();
        chk("req_redir_hold0", {s_req, s_addr}, {1'b1, 32'h8});
        set_br(1'b0, 1'b0, 32'h0);
        repeat (2) begin
            step();
            chk("req_redir_hold", {s_req, s_addr}, {1'b1, 32'h8});
        end
        bus.imem_ready = 1'b1;
        a0 = acc_q.size();
        n0 = dlv_pc.size();
        step();
        for (int i = 0; i < 40 && dlv_pc.size() <= n0; i++) step();
        chk("req_redir_old", acc_q[a0], 32'h8);
        chk("req_redir_new", acc_q[a0 + 1], 32'h100);
        chk("req_redir_pc",  dlv_pc[n0], 32'h100);

        // Redirect from HOLD to the top word, then wrap to 0.
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (3) step();
        set_br(1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        set_br(1'b0, 1'b0, 32'h0);
        step();
        chk("hold_redir_req", {s_req, s_addr}, {1'b1, 32'hFFFF_FFFC});
        bus.if_ready = 1'b1;
        for (int i = 0; i < 40 && dlv_pc.size() < 2; i++) step();
        chk("wrap_dlv0", dlv_pc[0], 32'hFFFF_FFFC);
        chk("wrap_dlv1", dlv_pc[1], 32'h0);

        // Misaligned target traps.
        do_reset();
        bus.imem_ready = 1'b1;
        bus.if_ready   = 1'b1;
        for (int i = 0; i < 40 && dlv_pc.size() < 1; i++) step();
        set_br(1'b1, 1'b1, 32'h102);
        step();
        set_br(1'b0, 1'b0, 32'h0);
        step();
        chk("mis_set", s_mis, 1'b1);
        repeat (5) begin
            step();
            chk("mis_noreq", s_req, 1'b0);
        end

        // Reset asserted mid-WAIT, stale response during the first cycle after release.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (3) step();
        chk("midwait_noreq", s_req, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        release_rst();
        stale_rv = 1'b1;
        lat_lo = 1; lat_hi = 1;
        repeat (8) step();
        chk("post_rst_first", first_req_cyc, 1);
        chk("post_rst_acc0", acc_q[0], RPC);

        // Randomised segments.
        lat_lo = 1; lat_hi = 4;
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            repeat (400) begin
                rand_inputs();
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
